// File: rtl/mem_decoder_pkg.sv
// rtl/mem_decoder_pkg.sv - region bounds, physical bases and enable/bank encodings for test_mem_decoder
package mem_decoder_pkg;

  localparam int PADDR_W = 13;

  // Region bounds are inclusive on both ends
  localparam logic [31:0] DATA_BASE   = 32'h1001_0000;
  localparam logic [31:0] DATA_LIMIT  = 32'h1001_0FFF;
  localparam logic [31:0] STACK_BASE  = 32'h7FFF_EFFC;
  localparam logic [31:0] STACK_LIMIT = 32'h7FFF_FFFB;
  localparam logic [31:0] VGA_BASE    = 32'h0000_B800;
  localparam logic [31:0] VGA_LIMIT   = 32'h0000_CABF;
  localparam logic [31:0] IO_BASE     = 32'hFFFF_0000;
  localparam logic [31:0] IO_LIMIT    = 32'hFFFF_000F;

  // Stack shares the RAM with data, placed directly above the 4 KiB data window
  localparam logic [PADDR_W-1:0] ZERO_PHYS  = 13'h0000;
  localparam logic [PADDR_W-1:0] STACK_PHYS = 13'h1000;

  localparam logic [2:0] MENAB_NONE = 3'b000;
  localparam logic [2:0] MENAB_RAM  = 3'b001;
  localparam logic [2:0] MENAB_VGA  = 3'b010;
  localparam logic [2:0] MENAB_IO   = 3'b100;

  localparam logic [1:0] MBANK_RAM = 2'b00;
  localparam logic [1:0] MBANK_VGA = 2'b01;
  localparam logic [1:0] MBANK_IO  = 2'b10;

endpackage

// File: rtl/mem_region_match.sv
// rtl/mem_region_match.sv - inclusive range compare and 13-bit physical offset for one region
module mem_region_match
  import mem_decoder_pkg::*;
(
  input  logic [31:0]        base,
  input  logic [31:0]        limit,
  input  logic [PADDR_W-1:0] phys_base,
  input  logic [31:0]        vAddr,
  output logic               hit,
  output logic [PADDR_W-1:0] offset
);

  assign hit    = (vAddr >= base) && (vAddr <= limit);
  // Offset is only meaningful on a hit; the truncation wraps silently otherwise
  assign offset = PADDR_W'(vAddr - base) + phys_base;

endmodule

// File: rtl/test_mem_decoder.sv
// rtl/test_mem_decoder.sv - virtual-to-physical memory decoder with optional fault latch (MEMDEC_FAULT_LATCH_EN)
module test_mem_decoder
  import mem_decoder_pkg::*;
#(
  parameter logic [PADDR_W-1:0] ILLEGAL_PADDR = 13'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        vAddr,
  input  logic               mWrite,
  input  logic               mRead,
  input  logic               faultClr,
  output logic [PADDR_W-1:0] pAddr,
  output logic [2:0]         mEnab,
  output logic [1:0]         mBank,
  output logic               iAddr,
  output logic               faultValid,
  output logic [31:0]        faultAddr,
  output logic               faultWrite,
  output logic [15:0]        faultCount
);

  logic               w_active;
  logic               w_hit_data, w_hit_stack, w_hit_vga, w_hit_io;
  logic [PADDR_W-1:0] w_off_data, w_off_stack, w_off_vga, w_off_io;

  // Read and write together is just another access
  assign w_active = mRead | mWrite;

  mem_region_match u_data (
    .base(DATA_BASE), .limit(DATA_LIMIT), .phys_base(ZERO_PHYS),
    .vAddr(vAddr), .hit(w_hit_data), .offset(w_off_data)
  );

  mem_region_match u_stack (
    .base(STACK_BASE), .limit(STACK_LIMIT), .phys_base(STACK_PHYS),
    .vAddr(vAddr), .hit(w_hit_stack), .offset(w_off_stack)
  );

  mem_region_match u_vga (
    .base(VGA_BASE), .limit(VGA_LIMIT), .phys_base(ZERO_PHYS),
    .vAddr(vAddr), .hit(w_hit_vga), .offset(w_off_vga)
  );

  mem_region_match u_io (
    .base(IO_BASE), .limit(IO_LIMIT), .phys_base(ZERO_PHYS),
    .vAddr(vAddr), .hit(w_hit_io), .offset(w_off_io)
  );

  // Zero-latency decode; regions are disjoint so the if-chain yields a single enable
  always_comb begin
    pAddr = ILLEGAL_PADDR;
    mEnab = MENAB_NONE;
    mBank = MBANK_RAM;
    iAddr = 1'b0;
    if (w_active) begin
      if (w_hit_data) begin
        pAddr = w_off_data;
        mEnab = MENAB_RAM;
      end else if (w_hit_stack) begin
        pAddr = w_off_stack;
        mEnab = MENAB_RAM;
      end else if (w_hit_vga) begin
        pAddr = w_off_vga;
        mEnab = MENAB_VGA;
        mBank = MBANK_VGA;
      end else if (w_hit_io) begin
        pAddr = w_off_io;
        mEnab = MENAB_IO;
        mBank = MBANK_IO;
      end else begin
        iAddr = 1'b1;
      end
    end
  end

`ifdef MEMDEC_FAULT_LATCH_EN
  logic r_fault_valid;
  logic [31:0] r_fault_addr;
  logic r_fault_write;
  logic [15:0] r_fault_count;
  logic w_valid_after_clr;

  // A clear takes effect before capture, so clear plus new fault latches the new one
  assign w_valid_after_clr = r_fault_valid & ~faultClr;

  // Latch first fault since last clear and count every faulting cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault_valid <= 1'b0;
      r_fault_addr  <= 32'h0;
      r_fault_write <= 1'b0;
      r_fault_count <= 16'h0;
    end else begin
      if (iAddr && !w_valid_after_clr) begin
        r_fault_valid <= 1'b1;
        r_fault_addr  <= vAddr;
        r_fault_write <= mWrite;
      end else begin
        r_fault_valid <= w_valid_after_clr;
      end
      if (faultClr) begin
        r_fault_count <= iAddr ? 16'h1 : 16'h0;
      end else if (iAddr && (r_fault_count != 16'hFFFF)) begin
        r_fault_count <= r_fault_count + 16'h1;
      end
    end
  end

  assign faultValid = r_fault_valid;
  assign faultAddr  = r_fault_addr;
  assign faultWrite = r_fault_write;
  assign faultCount = r_fault_count;
`else
  logic w_unused;

  // Without the fault latch the block is purely combinational
  assign w_unused   = ^{clk, rst, faultClr};
  assign faultValid = 1'b0;
  assign faultAddr  = 32'h0;
  assign faultWrite = 1'b0;
  assign faultCount = 16'h0;
`endif

endmodule

// File: tb/tb_test_mem_decoder.sv
// tb/tb_test_mem_decoder.sv - scoreboard bench for test_mem_decoder with directed vectors
module tb_test_mem_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] vAddr;
  logic        mWrite, mRead, faultClr;
  logic [12:0] pAddr;
  logic [2:0]  mEnab;
  logic [1:0]  mBank;
  logic        iAddr;
  logic        faultValid;
  logic [31:0] faultAddr;
  logic        faultWrite;
  logic [15:0] faultCount;

  int checks = 0;
  int errors = 0;
  bit stim_done = 1'b0;

  typedef struct {
    logic [12:0] pa;
    logic [2:0]  en;
    logic [1:0]  bk;
    logic        ia;
    logic        fv;
    logic [31:0] fa;
    logic        fw;
    logic [15:0] fc;
  } exp_t;

  exp_t sb_q[$];

  test_mem_decoder #(.ILLEGAL_PADDR(13'h0000)) dut (
    .clk(clk), .rst(rst), .vAddr(vAddr), .mWrite(mWrite), .mRead(mRead),
    .faultClr(faultClr), .pAddr(pAddr), .mEnab(mEnab), .mBank(mBank),
    .iAddr(iAddr), .faultValid(faultValid), .faultAddr(faultAddr),
    .faultWrite(faultWrite), .faultCount(faultCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Drive one vector just after a rising edge; fault expectations describe the
  // registered state left by earlier edges, which is what the monitor sees.
  task automatic vec(input logic [31:0] va, input logic wr, input logic rd,
                     input logic clr, input logic rs,
                     input logic [12:0] pa, input logic [2:0] en, input logic [1:0] bk,
                     input logic ia, input logic fv, input logic [31:0] fa,
                     input logic fw, input logic [15:0] fc);
    exp_t e;
    vAddr = va; mWrite = wr; mRead = rd; faultClr = clr; rst = rs;
    e.pa = pa; e.en = en; e.bk = bk; e.ia = ia;
`ifdef MEMDEC_FAULT_LATCH_EN
    e.fv = fv; e.fa = fa; e.fw = fw; e.fc = fc;
`else
    e.fv = 1'b0; e.fa = 32'h0; e.fw = 1'b0; e.fc = 16'h0;
`endif
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop one expectation per falling edge while vectors are pending
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pAddr", 32'(pAddr), 32'(e.pa));
        chk("mEnab", 32'(mEnab), 32'(e.en));
        chk("mBank", 32'(mBank), 32'(e.bk));
        chk("iAddr", 32'(iAddr), 32'(e.ia));
        chk("mEnab_onehot", 32'($countones(mEnab) <= 1), 32'd1);
        chk("faultValid", 32'(faultValid), 32'(e.fv));
        chk("faultAddr", faultAddr, e.fa);
        chk("faultWrite", 32'(faultWrite), 32'(e.fw));
        chk("faultCount", 32'(faultCount), 32'(e.fc));
      end
    end
  end

  initial begin
    rst = 1'b1; vAddr = 32'h0; mWrite = 1'b0; mRead = 1'b0; faultClr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //   vAddr         wr rd clr rs  pAddr    en      bk     ia  fv  faultAddr     fw  fc
    vec(32'h1001_0000, 0, 0, 0, 0, 13'h0000, 3'b000, 2'b00, 0, 0, 32'h0000_0000, 0, 16'd0);
    vec(32'h1001_0003, 0, 1, 0, 0, 13'h0003, 3'b001, 2'b00, 0, 0, 32'h0000_0000, 0, 16'd0);
    vec(32'h1001_0FFF, 0, 1, 0, 0, 13'h0FFF, 3'b001, 2'b00, 0, 0, 32'h0000_0000, 0, 16'd0);
    vec(32'h7FFF_EFFC, 1, 0, 0, 0, 13'h1000, 3'b001, 2'b00, 0, 0, 32'h0000_0000, 0, 16'd0);
    vec(32'h7FFF_FFFB, 1, 0, 0, 0, 13'h1FFF, 3'b001, 2'b00, 0, 0, 32'h0000_0000, 0, 16'd0);
    vec(32'h0000_CABF, 0, 1, 0, 0, 13'h12BF, 3'b010, 2'b01, 0, 0, 32'h0000_0000, 0, 16'd0);
    vec(32'hFFFF_000F, 1, 0, 0, 0, 13'h000F, 3'b100, 2'b10, 0, 0, 32'h0000_0000, 0, 16'd0);
    vec(32'h0000_B800, 1, 1, 0, 0, 13'h0000, 3'b010, 2'b01, 0, 0, 32'h0000_0000, 0, 16'd0);
    vec(32'h1000_FFFF, 0, 1, 0, 0, 13'h0000, 3'b000, 2'b00, 1, 0, 32'h0000_0000, 0, 16'd0);
    vec(32'h0000_0000, 0, 0, 0, 0, 13'h0000, 3'b000, 2'b00, 0, 1, 32'h1000_FFFF, 0, 16'd1);
    vec(32'h7FFF_EFFB, 1, 0, 0, 0, 13'h0000, 3'b000, 2'b00, 1, 1, 32'h1000_FFFF, 0, 16'd1);
    vec(32'h0000_0000, 0, 0, 0, 0, 13'h0000, 3'b000, 2'b00, 0, 1, 32'h1000_FFFF, 0, 16'd2);
    vec(32'h1001_1000, 1, 0, 1, 0, 13'h0000, 3'b000, 2'b00, 1, 1, 32'h1000_FFFF, 0, 16'd2);
    vec(32'h0000_0000, 0, 0, 0, 0, 13'h0000, 3'b000, 2'b00, 0, 1, 32'h1001_1000, 1, 16'd1);
    vec(32'h7FFF_FFFC, 1, 0, 0, 0, 13'h0000, 3'b000, 2'b00, 1, 1, 32'h1001_1000, 1, 16'd1);
    vec(32'h0000_CAC0, 0, 1, 0, 0, 13'h0000, 3'b000, 2'b00, 1, 1, 32'h1001_1000, 1, 16'd2);
    vec(32'h0000_B7FF, 0, 1, 0, 0, 13'h0000, 3'b000, 2'b00, 1, 1, 32'h1001_1000, 1, 16'd3);
    vec(32'hFFFF_0010, 1, 0, 0, 0, 13'h0000, 3'b000, 2'b00, 1, 1, 32'h1001_1000, 1, 16'd4);
    vec(32'hFFFE_FFFF, 1, 0, 0, 1, 13'h0000, 3'b000, 2'b00, 1, 1, 32'h1001_1000, 1, 16'd5);
    vec(32'h0000_0000, 0, 0, 1, 0, 13'h0000, 3'b000, 2'b00, 0, 0, 32'h0000_0000, 0, 16'd0);
    vec(32'h1000_FFFF, 1, 0, 0, 0, 13'h0000, 3'b000, 2'b00, 1, 0, 32'h0000_0000, 0, 16'd0);
    vec(32'h0000_0000, 0, 0, 1, 0, 13'h0000, 3'b000, 2'b00, 0, 1, 32'h1000_FFFF, 1, 16'd1);
    vec(32'h0000_0000, 0, 0, 0, 0, 13'h0000, 3'b000, 2'b00, 0, 0, 32'h1000_FFFF, 1, 16'd0);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    wait (stim_done);
    budget = 0;
    while (sb_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain act=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/test_mem_decoder.md
TEST_MEM_DECODER -- requirements
Module: test_mem_decoder

Interface
REQ-001 SHALL have one parameter: ILLEGAL_PADDR, default 13'h0000, the value driven on pAddr when no region is selected.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port vAddr, input, 32 bits: CPU virtual byte address.
REQ-005 SHALL have port mWrite, input, 1 bit: write request.
REQ-006 SHALL have port mRead, input, 1 bit: read request.
REQ-007 SHALL have port faultClr, input, 1 bit: clears the fault latch.
REQ-008 SHALL have port pAddr, output, 13 bits: physical offset within the selected memory.
REQ-009 SHALL have port mEnab, output, 3 bits: one-hot memory enable; bit0 = data/stack RAM, bit1 = VGA RAM, bit2 = I/O.
REQ-010 SHALL have port mBank, output, 2 bits: bank select; 00 = RAM, 01 = VGA, 10 = I/O.
REQ-011 SHALL have port iAddr, output, 1 bit: invalid-address flag.
REQ-012 SHALL have port faultValid, output, 1 bit: a fault is latched.
REQ-013 SHALL have port faultAddr, output, 32 bits: the latched faulting vAddr.
REQ-014 SHALL have port faultWrite, output, 1 bit: the latched mWrite of the fault.
REQ-015 SHALL have port faultCount, output, 16 bits: count of faults.

Function
REQ-016 The decode outputs pAddr, mEnab, mBank and iAddr SHALL be purely combinational from vAddr, mWrite and mRead, with zero latency.
REQ-017 An access is active when mRead | mWrite; asserting both at once SHALL be treated as an ordinary access.
REQ-018 Data region: 0x10010000..0x10010FFF SHALL give pAddr = vAddr - 0x10010000, mEnab = 001, mBank = 00.
REQ-019 Stack region: 0x7FFFEFFC..0x7FFFFFFB SHALL give pAddr = vAddr - 0x7FFFEFFC + 0x1000, mEnab = 001, mBank = 00.
REQ-020 VGA region: 0x0000B800..0x0000CABF SHALL give pAddr = vAddr - 0x0000B800, mEnab = 010, mBank = 01.
REQ-021 I/O region: 0xFFFF0000..0xFFFF000F SHALL give pAddr = vAddr - 0xFFFF0000, mEnab = 100, mBank = 10.
REQ-022 All range bounds SHALL be inclusive, and offsets SHALL be truncated to 13 bits.
REQ-023 An active access outside every region SHALL give iAddr = 1, mEnab = 000, mBank = 00, pAddr = ILLEGAL_PADDR.
REQ-024 With no access active, outputs SHALL be mEnab = 000, iAddr = 0, mBank = 00, pAddr = ILLEGAL_PADDR.
REQ-025 mEnab SHALL never have more than one bit set.

Reset
REQ-026 When rst = 1 at a clock edge, faultValid, faultAddr, faultWrite and faultCount SHALL all become 0.
REQ-027 rst SHALL have no effect on the combinational decode outputs.

Configuration
REQ-028 Macro MEMDEC_FAULT_LATCH_EN SHALL select the fault-latch feature.
REQ-029 With MEMDEC_FAULT_LATCH_EN defined, on each clock edge with rst = 0:
- if faultClr = 1, faultValid SHALL be cleared;
- then, if iAddr = 1 and faultValid is clear (after any clear in the same cycle), vAddr and mWrite SHALL be captured and faultValid set;
- a clear and a new fault in the same cycle SHALL therefore capture the new fault;
- faultCount SHALL increment on every cycle with iAddr = 1, saturating at 0xFFFF, and SHALL be cleared by faultClr unless a fault is also present in that cycle, in which case it becomes 1.
REQ-030 Without MEMDEC_FAULT_LATCH_EN, all fault outputs SHALL be tied to 0, faultClr SHALL be ignored, and no flops SHALL be inferred.

Structure
REQ-031 Package mem_decoder_pkg SHALL hold the region base and limit constants, the stack physical base 0x1000, the mEnab and mBank encodings, and the PADDR_W = 13 constant.
REQ-032 Sub-module mem_region_match SHALL perform the inclusive range compare and 13-bit offset for one region, with ports base, limit, phys_base, vAddr, hit and offset; four instances SHALL be used.

Verification
REQ-033 Read of 0x10010003 -> pAddr = 0x0003, mEnab = 001, mBank = 00, iAddr = 0; read of 0x10010FFF -> pAddr = 0x0FFF.
REQ-034 Write of 0x7FFFEFFC -> pAddr = 0x1000; write of 0x7FFFFFFB -> pAddr = 0x1FFF; write of 0x7FFFEFFB or 0x7FFFFFFC -> iAddr = 1, mEnab = 000.
REQ-035 Read of 0x0000CABF -> pAddr = 0x12BF, mEnab = 010, mBank = 01; 0x0000B7FF and 0x0000CAC0 -> iAddr = 1.
REQ-036 Write of 0xFFFF000F -> pAddr = 0x000F, mEnab = 100, mBank = 10; 0xFFFF0010 and 0xFFFEFFFF -> iAddr = 1.
REQ-037 0x10010000 with mRead = mWrite = 0 -> mEnab = 000, iAddr = 0.
REQ-038 With MEMDEC_FAULT_LATCH_EN: reset, read of 0x1000FFFF for one cycle -> faultValid = 1, faultAddr = 0x1000FFFF, faultCount = 1; a second fault leaves faultAddr unchanged and gives faultCount = 2; faultClr together with a fault at 0x10011000 -> faultAddr = 0x10011000, faultCount = 1; rst mid-operation -> all fault outputs 0 on the next edge.
